// File: rtl/ps2_player_input_ctrl.sv
// PS/2 set-2 scancode sequencer: decodes E0/F0 prefixes into make/break events and
// turns them into held keys, last-pressed direction, rate-limited move grants and bomb pulses for two players.
module ps2_player_lane #(
    parameter logic [4:0][8:0] KEYS = '0  // {bomb,right,left,down,up} as {ext,code}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_vld_i,
    input  logic       evt_brk_i,
    input  logic [8:0] evt_code_i,
    input  logic       tick_i,
    output logic [4:0] held_o,
    output logic       move_valid_o,
    output logic [1:0] move_dir_o,
    output logic       bomb_o
);
    logic [4:0] hit;
    logic [4:0] held_q, held_d;
    logic [1:0] last_q, last_d;
    logic       act_q, act_d;
    logic       mv_q, bomb_q, bomb_d;
    logic [1:0] dir_q;

    always_comb begin
        hit    = '0;
        held_d = held_q;
        last_d = last_q;
        act_d  = act_q;
        for (int k = 0; k < 5; k++) begin
            hit[k] = evt_vld_i && (evt_code_i == KEYS[k]);
            if (hit[k]) held_d[k] = !evt_brk_i;
        end
        for (int k = 0; k < 4; k++) begin
            if (hit[k] && !evt_brk_i && !held_q[k]) begin
                last_d = 2'(k);
                act_d  = 1'b1;
            end
        end
        // Releasing the active direction falls back to a fixed priority, not press order.
        if (evt_brk_i && hit[last_q]) begin
            act_d = |held_d[3:0];
            if (held_d[0])      last_d = 2'd0;
            else if (held_d[1]) last_d = 2'd1;
            else if (held_d[2]) last_d = 2'd2;
            else if (held_d[3]) last_d = 2'd3;
        end
        bomb_d = hit[4] && !evt_brk_i && !held_q[4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            last_q <= '0;
            act_q  <= 1'b0;
            mv_q   <= 1'b0;
            dir_q  <= '0;
            bomb_q <= 1'b0;
        end else begin
            held_q <= held_d;
            last_q <= last_d;
            act_q  <= act_d;
            // Grant uses pre-event state: a make on the tick cycle waits for the next tick.
            mv_q   <= tick_i && act_q;
            if (tick_i && act_q) dir_q <= last_q;
            bomb_q <= bomb_d;
        end
    end

    assign held_o       = held_q;
    assign move_valid_o = mv_q;
    assign move_dir_o   = dir_q;
    assign bomb_o       = bomb_q;
endmodule

module ps2_player_input_ctrl #(
    parameter int unsigned TICK_CYCLES    = 2500000,
    parameter int unsigned PREFIX_TIMEOUT = 50000,
    parameter logic [8:0]  B_UP    = 9'h01D,
    parameter logic [8:0]  B_DOWN  = 9'h01B,
    parameter logic [8:0]  B_LEFT  = 9'h01C,
    parameter logic [8:0]  B_RIGHT = 9'h023,
    parameter logic [8:0]  B_BOMB  = 9'h029,
    parameter logic [8:0]  R_UP    = 9'h175,
    parameter logic [8:0]  R_DOWN  = 9'h172,
    parameter logic [8:0]  R_LEFT  = 9'h16B,
    parameter logic [8:0]  R_RIGHT = 9'h174,
    parameter logic [8:0]  R_BOMB  = 9'h05A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic [4:0] b_held,
    output logic       b_move_valid,
    output logic [1:0] b_move_dir,
    output logic       b_bomb,
    output logic [4:0] r_held,
    output logic       r_move_valid,
    output logic [1:0] r_move_dir,
    output logic       r_bomb
);
    localparam int NUM_PLAYERS = 2;
    localparam int TC_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [NUM_PLAYERS-1:0][4:0][8:0] PKEYS = '{
        '{R_BOMB, R_RIGHT, R_LEFT, R_DOWN, R_UP},
        '{B_BOMB, B_RIGHT, B_LEFT, B_DOWN, B_UP}};

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t            state_q;
    logic [TO_W-1:0]   to_q;
    logic [TC_W-1:0]   tc_q;
    logic              tick;
    logic              evt_vld, evt_brk;
    logic [8:0]        evt_code;
    logic              is_pfx;

    logic [NUM_PLAYERS-1:0][4:0] held_w;
    logic [NUM_PLAYERS-1:0]      mv_w, bomb_w;
    logic [NUM_PLAYERS-1:0][1:0] dir_w;

    assign is_pfx = (byte_data == 8'hE0) || (byte_data == 8'hF0);
    assign tick   = (tc_q == TC_W'(TICK_CYCLES - 1));

    always_comb begin
        evt_vld  = 1'b0;
        evt_brk  = 1'b0;
        evt_code = {1'b0, byte_data};
        if (byte_valid) begin
            unique case (state_q)
                S_IDLE:    evt_vld = !is_pfx;
                S_EXT:     begin evt_vld = !is_pfx; evt_code[8] = 1'b1; end
                S_BRK:     begin evt_vld = 1'b1; evt_brk = 1'b1; end
                S_EXT_BRK: begin evt_vld = 1'b1; evt_brk = 1'b1; evt_code[8] = 1'b1; end
                default:   evt_vld = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            tc_q    <= '0;
        end else begin
            tc_q <= tick ? '0 : tc_q + 1'b1;
            if (byte_valid) begin
                to_q <= '0;
                unique case (state_q)
                    S_IDLE: begin
                        if (byte_data == 8'hE0)      state_q <= S_EXT;
                        else if (byte_data == 8'hF0) state_q <= S_BRK;
                    end
                    S_EXT: begin
                        if (byte_data == 8'hF0)      state_q <= S_EXT_BRK;
                        else if (byte_data != 8'hE0) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q != S_IDLE) begin
                // Stalled prefix (lost byte) is abandoned silently.
                if (to_q == TO_W'(PREFIX_TIMEOUT - 1)) begin
                    state_q <= S_IDLE;
                    to_q    <= '0;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        ps2_player_lane #(.KEYS(PKEYS[p])) u_lane (
            .clk          (clk),
            .rst          (reset),
            .evt_vld_i    (evt_vld),
            .evt_brk_i    (evt_brk),
            .evt_code_i   (evt_code),
            .tick_i       (tick),
            .held_o       (held_w[p]),
            .move_valid_o (mv_w[p]),
            .move_dir_o   (dir_w[p]),
            .bomb_o       (bomb_w[p])
        );
    end

    assign b_held       = held_w[0];
    assign b_move_valid = mv_w[0];
    assign b_move_dir   = dir_w[0];
    assign b_bomb       = bomb_w[0];
    assign r_held       = held_w[1];
    assign r_move_valid = mv_w[1];
    assign r_move_dir   = dir_w[1];
    assign r_bomb       = bomb_w[1];
endmodule

// File: tb/tb_ps2_player_input_ctrl.sv
// Bench for ps2_player_input_ctrl: directed vectors, plan sequences and random bytes vs. a reference model.
module tb_ps2_player_input_ctrl;
    localparam int TICK = 8;
    localparam int TO   = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [4:0] b_held, r_held;
    logic       b_move_valid, r_move_valid, b_bomb, r_bomb;
    logic [1:0] b_move_dir, r_move_dir;

    ps2_player_input_ctrl #(.TICK_CYCLES(TICK), .PREFIX_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
        .b_held(b_held), .b_move_valid(b_move_valid), .b_move_dir(b_move_dir), .b_bomb(b_bomb),
        .r_held(r_held), .r_move_valid(r_move_valid), .r_move_dir(r_move_dir), .r_bomb(r_bomb));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int keys [2][5] = '{'{'h01D, 'h01B, 'h01C, 'h023, 'h029},
                        '{'h175, 'h172, 'h16B, 'h174, 'h05A}};
    // Reference state: pending prefix flags, counters, per-player held set and direction.
    bit         m_pe, m_pf;
    int         m_to, m_tc;
    logic [4:0] m_held [2];
    int         m_last [2];
    bit         m_act  [2];
    bit         e_mv   [2];
    int         e_dir  [2];
    bit         e_bomb [2];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pe = 0; m_pf = 0; m_to = 0; m_tc = 0;
        for (int p = 0; p < 2; p++) begin
            m_held[p] = '0; m_last[p] = 0; m_act[p] = 0;
            e_mv[p] = 0; e_dir[p] = 0; e_bomb[p] = 0;
        end
    endtask

    task automatic model_event(input bit brk, input int code);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 5; k++)
                if (keys[p][k] == code) begin
                    if (!brk) begin
                        if (!m_held[p][k]) begin
                            if (k == 4) e_bomb[p] = 1;
                            else begin m_last[p] = k; m_act[p] = 1; end
                        end
                        m_held[p][k] = 1;
                    end else begin
                        m_held[p][k] = 0;
                        if (k < 4 && k == m_last[p]) begin
                            int nd;
                            nd = -1;
                            for (int j = 3; j >= 0; j--) if (m_held[p][j]) nd = j;
                            if (nd < 0) m_act[p] = 0;
                            else m_last[p] = nd;
                        end
                    end
                end
    endtask

    task automatic model_step(input bit bv, input logic [7:0] bd);
        for (int p = 0; p < 2; p++) begin
            e_mv[p] = (m_tc == TICK - 1) && m_act[p];
            if (e_mv[p]) e_dir[p] = m_last[p];
            e_bomb[p] = 0;
        end
        m_tc = (m_tc + 1) % TICK;
        if (bv) begin
            m_to = 0;
            if (m_pf) begin
                model_event(1, {23'd0, m_pe, bd});
                m_pe = 0; m_pf = 0;
            end else if (bd == 8'hF0) m_pf = 1;
            else if (bd == 8'hE0) m_pe = 1;
            else begin
                model_event(0, {23'd0, m_pe, bd});
                m_pe = 0;
            end
        end else if (m_pe || m_pf) begin
            m_to++;
            if (m_to == TO) begin m_pe = 0; m_pf = 0; m_to = 0; end
        end
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge and compare.
    task automatic cyc(input bit bv, input logic [7:0] bd);
        bit ok;
        byte_valid = bv;
        byte_data  = bd;
        model_step(bv, bd);
        @(posedge clk);
        #1;
        ok = (b_held === m_held[0]) && (r_held === m_held[1]) &&
             (b_move_valid === e_mv[0]) && (r_move_valid === e_mv[1]) &&
             (b_bomb === e_bomb[0]) && (r_bomb === e_bomb[1]) &&
             (!e_mv[0] || b_move_dir === 2'(e_dir[0])) &&
             (!e_mv[1] || r_move_dir === 2'(e_dir[1]));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL model t=%0t actual bh=%b rh=%b bmv=%b bd=%0d rmv=%b rd=%0d bb=%b rb=%b expected bh=%b rh=%b bmv=%b bd=%0d rmv=%b rd=%0d bb=%b rb=%b",
                     $time, b_held, r_held, b_move_valid, b_move_dir, r_move_valid, r_move_dir, b_bomb, r_bomb,
                     m_held[0], m_held[1], e_mv[0], e_dir[0], e_mv[1], e_dir[1], e_bomb[0], e_bomb[1]);
        end
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1, b);
    endtask

    task automatic wait_grant(input int p, input int d, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * TICK && !found; i++) begin
            cyc(0, 8'h00);
            if ((p == 0 ? b_move_valid : r_move_valid) === 1'b1) begin
                found = 1;
                chk(name, int'(p == 0 ? b_move_dir : r_move_dir), d);
            end
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic no_grant(input int p, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * TICK; i++) begin
            cyc(0, 8'h00);
            seen |= (p == 0 ? b_move_valid : r_move_valid);
        end
        chk(name, int'(seen), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({b_held, r_held, b_move_valid, b_move_dir, b_bomb, r_move_valid, r_move_dir, r_bomb}), 0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [4:0] bh;
        logic [4:0] rh;
        logic       bb;
        logic       rb;
    } vec_t;

    vec_t tbl [$];

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                              8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h11, 8'hE0};

    initial begin
        tbl.push_back('{8'h1D, 5'b00001, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 5'b00001, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h1D, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 5'b10000, 5'b00000, 1'b1, 1'b0});
        tbl.push_back('{8'h29, 5'b10000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 5'b10000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 5'b10000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 5'b10000, 5'b00000, 1'b1, 1'b0});
        tbl.push_back('{8'hF0, 5'b10000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'hE0, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 5'b00000, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{8'hE0, 5'b00000, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 5'b00000, 5'b00001, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 5'b00000, 5'b10000, 1'b0, 1'b1});
        tbl.push_back('{8'hF0, 5'b00000, 5'b10000, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 5'b00000, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 5'b00000, 5'b00000, 1'b0, 1'b0});

        reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].b);
            chk($sformatf("vec%0d_bheld", i), int'(b_held), int'(tbl[i].bh));
            chk($sformatf("vec%0d_rheld", i), int'(r_held), int'(tbl[i].rh));
            chk($sformatf("vec%0d_bomb", i), int'({b_bomb, r_bomb}), int'({tbl[i].bb, tbl[i].rb}));
        end

        // Blue up held: grants dir 0, none after release.
        send(8'h1D); idle(TICK + 1);
        wait_grant(0, 0, "b_up_grant");
        send(8'hF0); send(8'h1D); idle(TICK + 1);
        no_grant(0, "b_up_released");

        // A then D: last pressed wins; releasing D falls back to A.
        send(8'h1C); idle(TICK + 1);
        wait_grant(0, 2, "b_left_grant");
        send(8'h23); idle(TICK + 1);
        wait_grant(0, 3, "b_right_over_left");
        send(8'hF0); send(8'h23); idle(TICK + 1);
        wait_grant(0, 2, "b_fallback_left");
        send(8'hF0); send(8'h1C); idle(TICK + 1);
        no_grant(0, "b_all_released");

        // Red extended up; blue stays quiet.
        send(8'hE0); send(8'h75); idle(TICK + 1);
        wait_grant(1, 0, "r_up_grant");
        no_grant(0, "blue_quiet_during_red");
        send(8'hE0); send(8'hF0); send(8'h75); idle(TICK + 1);
        no_grant(1, "r_up_released");

        // Stalled E0 times out; next 1D is plain blue up.
        send(8'hE0); idle(20); send(8'h1D);
        chk("timeout_bheld", int'(b_held), 5'b00001);
        chk("timeout_rheld", int'(r_held), 0);
        send(8'hF0); send(8'h1D);
        // Short gap after E0 keeps the prefix.
        send(8'hE0); idle(TO - 2); send(8'h75);
        chk("no_timeout_rheld", int'(r_held), 5'b00001);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Reset mid-sequence with keys held and a break prefix pending.
        send(8'h1D); send(8'hE0); send(8'h74); idle(TICK + 2); send(8'hF0);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("mid_reset_held");
        reset = 1'b0;
        send(8'h23);
        chk("post_reset_make", int'(b_held), 5'b01000);
        send(8'hF0); send(8'h23);
        chk("post_reset_break", int'(b_held), 0);
        send(8'hF0); send(8'h75);
        chk("post_reset_stray_break", int'(r_held), 0);

        // Random byte stream against the model.
        for (int i = 0; i < 1500; i++) begin
            int g;
            send(pool[$urandom_range(0, 13)]);
            g = $urandom_range(0, 15);
            if (g == 15) idle(TO + 2);
            else if (g > 10) idle(g - 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/ps2_player_input_ctrl.md
Name: ps2_player_input_ctrl

Overview:
- Sequences the raw PS/2 set-2 scancode byte stream into per-player game controls for two players (blue, red) sharing one keyboard.
- Decodes E0/F0 prefixes and tracks held keys per player.
- Resolves each player's held direction keys with last-pressed-wins priority.
- Issues rate-limited move grants on a common tick, plus edge-triggered bomb pulses.
- Sits between the PS/2 byte receiver and the game logic in the CLOCK_50 domain.

Parameters:
- TICK_CYCLES, 2500000, clk cycles between move grants (20 Hz at 50 MHz); minimum 2.
- PREFIX_TIMEOUT, 50000, idle clk cycles after a prefix byte before the decoder abandons the sequence (1 ms).
- B_UP, 9'h01D, blue up key as {ext,code} (W).
- B_DOWN, 9'h01B, blue down key (S).
- B_LEFT, 9'h01C, blue left key (A).
- B_RIGHT, 9'h023, blue right key (D).
- B_BOMB, 9'h029, blue bomb key (Space).
- R_UP, 9'h175, red up key (E0 75, arrow up).
- R_DOWN, 9'h172, red down key (E0 72).
- R_LEFT, 9'h16B, red left key (E0 6B).
- R_RIGHT, 9'h174, red right key (E0 74).
- R_BOMB, 9'h05A, red bomb key (Enter).

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  one-cycle strobe: byte_data holds a complete received byte
- byte_data  in  8  received scancode byte
- b_held  out  5  blue held keys {bomb,right,left,down,up}
- b_move_valid  out  1  one-cycle blue move grant
- b_move_dir  out  2  blue direction (0 up, 1 down, 2 left, 3 right); valid with b_move_valid
- b_bomb  out  1  one-cycle blue bomb pulse
- r_held  out  5  red held keys, same order
- r_move_valid  out  1  one-cycle red move grant
- r_move_dir  out  2  red direction
- r_bomb  out  1  one-cycle red bomb pulse

Behaviour:
- All outputs are registered. On reset, every output is 0, the prefix FSM is in IDLE, and the tick counter, timeout counter, last-direction registers and dir_active flags are 0.
- Prefix FSM, one transition per byte_valid:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte emits make{0,byte} and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte emits make{1,byte} and goes to IDLE.
  - BRK: any byte emits break{0,byte} and goes to IDLE.
  - EXT_BRK: any byte emits break{1,byte} and goes to IDLE.
  - Outside IDLE, the timeout counter counts cycles without byte_valid. At PREFIX_TIMEOUT the FSM returns to IDLE with no event. Any byte_valid clears the counter.
- Events are compared against all 10 key parameters. Unmatched events are ignored. Held bits update on the cycle after the terminating byte_valid: make sets the bit, break clears it.
- Direction arbitration, per player:
  - Make of a direction key whose held bit was 0: last_dir <= that direction, dir_active <= 1.
  - Make of an already-held key (typematic repeat) changes nothing.
  - Break of the key equal to last_dir: fall back to the remaining held direction keys with priority up > down > left > right. If none are held, dir_active <= 0.
  - Break of any other key leaves last_dir unchanged.
- Tick: a free-running counter counts 0..TICK_CYCLES-1 and wraps. On the terminal count, each player with dir_active=1 gets move_valid=1 and move_dir=last_dir in the next cycle. The tick samples arbitration state from before any same-cycle key event, so a make arriving on the terminal-count cycle is first granted at the following tick.
- Bomb: make of a bomb key whose held bit was 0 pulses bomb for exactly one cycle, 1 cycle after the byte. Repeat makes and breaks produce no pulse.
- The two players are fully independent and may both be granted on the same tick.
- Asserting reset mid-sequence (prefix pending, keys held) clears everything. A break received after reset for a non-held key is harmless.
- byte_valid on consecutive cycles must be accepted back to back with no dropped bytes.

Test Plan (TICK_CYCLES=8, PREFIX_TIMEOUT=16):
- Bytes 1D, then F0 1D -> b_held=00001 one cycle after 1D; b_move_valid pulses with dir 0 at each tick while held; b_held=0 after the break and no further grants.
- Blue A (1C) then D (23) while A is held -> grants dir 3. Release D -> grants dir 2. Release A -> no grants.
- E0 75, then E0 F0 75 -> r_held[0] rises then falls; red grants dir 0 only while held; blue outputs stay 0 throughout.
- 29, 29, 29 (typematic repeat), then F0 29 -> exactly one b_bomb pulse. A second press after release -> a second pulse.
- E0 followed by 20 idle cycles, then 1D -> the timeout returns the FSM to IDLE; 1D is decoded as blue up (b_held=00001), not as 9'h11D.
- Hold 1D and 74-with-E0, pulse reset mid-sequence after an F0 -> all outputs are 0 from reset assertion; the next bytes 23, F0 23 are decoded correctly.
